// File: rtl/prince_pkg.sv
// Shared PRINCE definitions: S-boxes, M'/SR linear layers, round constants and engine state.
// Purely combinational helpers; no latency or flow control of their own.
package prince_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [63:0] ALPHA = 64'hC0AC29B7C97C50DD;

    // Nibble v of each table lives at [4*v +: 4].
    localparam logic [63:0] SBOX_TBL  = 64'h4D5E087619CA23FB;
    localparam logic [63:0] SBOXI_TBL = 64'h1CE5046A98DF237B;

    // Column i of the 16x16 matrix (contribution of input bit i) at [16*i +: 16].
    localparam logic [255:0] MHAT0_COLS = {
        16'h0888, 16'h4044, 16'h2202, 16'h1110, 16'h8880, 16'h0444, 16'h2022, 16'h1101,
        16'h8808, 16'h4440, 16'h0222, 16'h1011, 16'h8088, 16'h4404, 16'h2220, 16'h0111};
    localparam logic [255:0] MHAT1_COLS = {
        16'h8880, 16'h0444, 16'h2022, 16'h1101, 16'h8808, 16'h4440, 16'h0222, 16'h1011,
        16'h8088, 16'h4404, 16'h2220, 16'h0111, 16'h0888, 16'h4044, 16'h2202, 16'h1110};

    function automatic logic [63:0] s_layer(input logic [63:0] x, input logic inv);
        logic [63:0] y;
        y = '0;
        for (int n = 0; n < 16; n++) begin
            y[4*n +: 4] = inv ? SBOXI_TBL[4*x[4*n +: 4] +: 4] : SBOX_TBL[4*x[4*n +: 4] +: 4];
        end
        return y;
    endfunction

    function automatic logic [15:0] m_hat(input logic [15:0] h, input logic sel);
        logic [15:0] y;
        y = '0;
        for (int i = 0; i < 16; i++) begin
            if (h[i]) y ^= sel ? MHAT1_COLS[16*i +: 16] : MHAT0_COLS[16*i +: 16];
        end
        return y;
    endfunction

    // Involutive, so it serves both directions.
    function automatic logic [63:0] m_prime(input logic [63:0] x);
        return {m_hat(x[63:48], 1'b0), m_hat(x[47:32], 1'b1),
                m_hat(x[31:16], 1'b1), m_hat(x[15:0], 1'b0)};
    endfunction

    // Nibble j (0 = most significant) takes nibble 5j mod 16; the inverse uses 13j mod 16.
    function automatic logic [63:0] shift_rows(input logic [63:0] x, input logic inv);
        logic [63:0] y;
        int          src;
        y = '0;
        for (int j = 0; j < 16; j++) begin
            src = inv ? (13 * j) % 16 : (5 * j) % 16;
            y[60 - 4*j +: 4] = x[60 - 4*src +: 4];
        end
        return y;
    endfunction

    function automatic logic [63:0] rc(input logic [3:0] idx);
        case (idx)
            4'd0:    return 64'h0000000000000000;
            4'd1:    return 64'h13198a2e03707344;
            4'd2:    return 64'ha4093822299f31d0;
            4'd3:    return 64'h082efa98ec4e6c89;
            4'd4:    return 64'h452821e638d01377;
            4'd5:    return 64'hbe5466cf34e90c6c;
            4'd6:    return 64'h7ef84f78fd955cb1;
            4'd7:    return 64'h85840851f1ac43aa;
            4'd8:    return 64'hc882d32f25323c54;
            4'd9:    return 64'h64a51195e0e3610d;
            4'd10:   return 64'hd3b5a399ca0c2399;
            4'd11:   return 64'hc0ac29b7c97c50dd;
            default: return 64'h0000000000000000;
        endcase
    endfunction

endpackage

// File: rtl/prince_step.sv
// One PRINCE core step selected by idx (forward rounds, middle, inverse rounds, final); combinational.
// No flow control: the engine chains UNROLL of these between its state registers.
module prince_step
    import prince_pkg::*;
(
    input  logic [63:0] x,
    input  logic [63:0] kc,
    input  logic [3:0]  idx,
    output logic [63:0] y
);

    always_comb begin
        y = x;
        if (idx <= 4'd4) begin
            y = shift_rows(m_prime(s_layer(x, 1'b0)), 1'b0) ^ kc ^ rc(idx + 4'd1);
        end else if (idx == 4'd5) begin
            y = m_prime(s_layer(x, 1'b0));
        end else if (idx <= 4'd10) begin
            y = m_prime(shift_rows(s_layer(x, 1'b1) ^ kc ^ rc(idx), 1'b1));
        end else begin
            y = s_layer(x, 1'b1) ^ kc ^ rc(idx);
        end
    end

endmodule

// File: rtl/prince_engine.sv
// PRINCE encrypt/decrypt engine, UNROLL core steps per clock; result valid NCYC+1 cycles after accept.
// Result is held in DONE until out_ready; a new block is taken in the same cycle the result leaves.
module prince_engine
    import prince_pkg::*;
#(
    parameter int UNROLL = 6
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_mode,
    input  logic [63:0]  in_data,
    input  logic [127:0] in_key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [63:0]  out_data,
    output logic         busy
);

    localparam int          NCYC = 12 / UNROLL;
    localparam logic [3:0]  LAST = 4'(NCYC - 1);

    if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 3 || UNROLL == 4 || UNROLL == 6 || UNROLL == 12))
    begin : g_bad_unroll
        $error("prince_engine: UNROLL must be one of 1,2,3,4,6,12");
    end

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [63:0] x_q, x_d;
    logic [63:0] wo_q, wo_d;
    logic [63:0] kc_q, kc_d;
    logic [63:0] out_q, out_d;

    logic [63:0] k0, k1, k0p, wi_in, wo_in, kc_in;
    logic        accept;
    logic [UNROLL:0][63:0] chain;

    // Decryption reuses the encrypt datapath: swap the whitening keys and fold ALPHA into k1.
    assign k0     = in_key[127:64];
    assign k1     = in_key[63:0];
    assign k0p    = {k0[0], k0[63:2], k0[1] ^ k0[63]};
    assign wi_in  = in_mode ? k0p : k0;
    assign wo_in  = in_mode ? k0 : k0p;
    assign kc_in  = in_mode ? (k1 ^ ALPHA) : k1;
    assign accept = in_valid & in_ready;

    assign chain[0] = x_q;
    for (genvar i = 0; i < UNROLL; i++) begin : g_step
        logic [3:0] step_idx;
        assign step_idx = 4'(cnt_q * 4'(UNROLL)) + 4'(i);
        prince_step u_step (
            .x   (chain[i]),
            .kc  (kc_q),
            .idx (step_idx),
            .y   (chain[i+1])
        );
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            x_q     <= '0;
            wo_q    <= '0;
            kc_q    <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            wo_q    <= wo_d;
            kc_q    <= kc_d;
            out_q   <= out_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        wo_d    = wo_q;
        kc_d    = kc_q;
        out_d   = out_q;
        if (accept) begin
            state_d = RUN;
            cnt_d   = '0;
            x_d     = in_data ^ wi_in ^ kc_in ^ rc(4'd0);
            wo_d    = wo_in;
            kc_d    = kc_in;
        end else begin
            case (state_q)
                RUN: begin
                    x_d   = chain[UNROLL];
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == LAST) begin
                        state_d = DONE;
                        out_d   = chain[UNROLL] ^ wo_q;
                    end
                end
                DONE: begin
                    if (out_ready) state_d = IDLE;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = (state_q != IDLE);
        case (state_q)
            IDLE: in_ready = 1'b1;
            DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
            end
            default: ;
        endcase
    end

    assign out_data = out_q;

endmodule

// File: tb/tb_prince_engine.sv
// Bench for prince_engine at UNROLL = 1, 2, 6, 12 against known-answer vectors and a reference cipher model.
// Covers latency, DONE stall, back-to-back alternating modes and asynchronous reset mid-block.
module tb_prince_engine;

    localparam logic [63:0] ALPHA = 64'hC0AC29B7C97C50DD;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [3:0]         rst_n, in_valid, in_ready, in_mode, out_valid, out_ready, busy;
    logic [3:0][63:0]   in_data, out_data;
    logic [3:0][127:0]  in_key;

    int n_chk = 0;
    int n_err = 0;

    logic [3:0]   sbox_t  [16];
    logic [63:0]  rc_t    [12];
    logic [63:0]  kat_pt  [5];
    logic [63:0]  kat_ct  [5];
    logic [127:0] kat_key [5];

    function automatic int un_of(input int k);
        case (k)
            0:       return 1;
            1:       return 2;
            2:       return 6;
            default: return 12;
        endcase
    endfunction

    for (genvar g = 0; g < 4; g++) begin : g_dut
        prince_engine #(.UNROLL(un_of(g))) dut (
            .clk       (clk),
            .reset     (rst_n[g]),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .in_mode   (in_mode[g]),
            .in_data   (in_data[g]),
            .in_key    (in_key[g]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .out_data  (out_data[g]),
            .busy      (busy[g])
        );
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [63:0] m_sbox(input logic [63:0] x, input bit inv);
        logic [63:0] y;
        logic [3:0]  v;
        y = '0;
        for (int n = 0; n < 16; n++) begin
            v = x[4*n +: 4];
            if (!inv) y[4*n +: 4] = sbox_t[v];
            else for (int c = 0; c < 16; c++) if (sbox_t[c] == v) y[4*n +: 4] = 4'(c);
        end
        return y;
    endfunction

    // Each output bit is the parity of its bit column minus one nibble picked by position.
    function automatic logic [63:0] m_mprime(input logic [63:0] x);
        logic [63:0] y;
        bit          p;
        int          c, src;
        y = '0;
        for (int blk = 0; blk < 4; blk++) begin
            c = (blk == 1 || blk == 2) ? 1 : 0;
            for (int j = 0; j < 4; j++) begin
                for (int b = 0; b < 4; b++) begin
                    p = 1'b0;
                    for (int i = 0; i < 4; i++) p ^= x[16*blk + 4*i + b];
                    src = (b + 3 + c - j + 4) % 4;
                    y[16*blk + 4*j + b] = p ^ x[16*blk + 4*src + b];
                end
            end
        end
        return y;
    endfunction

    // Row r (nibbles r, r+4, r+8, r+12 from the top) rotates left by 16r bits.
    function automatic logic [63:0] m_sr(input logic [63:0] x, input bit inv);
        logic [63:0] y, row;
        int          sh;
        y = '0;
        for (int r = 0; r < 4; r++) begin
            row = x & (64'hF000F000F000F000 >> (4*r));
            sh  = inv ? (64 - 16*r) % 64 : 16*r;
            y   = y | (row << sh) | (row >> (64 - sh));
        end
        return y;
    endfunction

    function automatic logic [63:0] ref_enc(input logic [63:0] pt, input logic [127:0] key);
        logic [63:0] k0, k1, k0p, x;
        k0  = key[127:64];
        k1  = key[63:0];
        k0p = {k0[0], k0[63:1]} ^ {63'd0, k0[63]};
        x   = pt ^ k0 ^ k1 ^ rc_t[0];
        for (int r = 1; r <= 5; r++) x = m_sr(m_mprime(m_sbox(x, 0)), 0) ^ rc_t[r] ^ k1;
        x = m_sbox(m_mprime(m_sbox(x, 0)), 1);
        for (int r = 6; r <= 10; r++) x = m_sbox(m_mprime(m_sr(x ^ k1 ^ rc_t[r], 1)), 1);
        return x ^ k1 ^ rc_t[11] ^ k0p;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic send(input int k, input bit mode, input logic [63:0] data,
                        input logic [127:0] key, input string tag);
        @(negedge clk);
        chk({tag, " in_ready"}, 64'(in_ready[k]), 64'd1);
        in_valid[k] = 1'b1;
        in_mode[k]  = mode;
        in_data[k]  = data;
        in_key[k]   = key;
        @(posedge clk);
        @(negedge clk);
        in_valid[k] = 1'b0;
        in_mode[k]  = ~mode;
        in_data[k]  = {$urandom, $urandom};
        in_key[k]   = {$urandom, $urandom, $urandom, $urandom};
    endtask

    // lat counts cycles from the accept edge; -1 when the budget runs out.
    task automatic wait_out(input int k, output int lat);
        lat = -1;
        for (int c = 1; c <= 40; c++) begin
            if (out_valid[k]) begin
                lat = c;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic take(input int k);
        out_ready[k] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready[k] = 1'b0;
    endtask

    task automatic run_block(input int k, input bit mode, input logic [63:0] data,
                             input logic [127:0] key, input logic [63:0] exp, input string tag);
        int lat;
        send(k, mode, data, key, tag);
        wait_out(k, lat);
        chk({tag, " latency"}, 64'(lat), 64'(12 / un_of(k) + 1));
        chk({tag, " data"}, out_data[k], exp);
        take(k);
        chk({tag, " out_valid after take"}, 64'(out_valid[k]), 64'd0);
        chk({tag, " busy after take"}, 64'(busy[k]), 64'd0);
    endtask

    task automatic stall_test(input int k);
        logic [63:0]  pt, ct;
        logic [127:0] key;
        int           lat;
        string        tag;
        tag = $sformatf("u%0d stall", un_of(k));
        pt  = {$urandom, $urandom};
        key = {$urandom, $urandom, $urandom, $urandom};
        ct  = ref_enc(pt, key);
        send(k, 1'b0, pt, key, tag);
        wait_out(k, lat);
        chk({tag, " latency"}, 64'(lat), 64'(12 / un_of(k) + 1));
        in_valid[k] = 1'b1;
        in_mode[k]  = 1'b1;
        in_data[k]  = {$urandom, $urandom};
        for (int s = 0; s < 5; s++) begin
            chk($sformatf("%s hold%0d data", tag, s), out_data[k], ct);
            chk($sformatf("%s hold%0d in_ready", tag, s), 64'(in_ready[k]), 64'd0);
            chk($sformatf("%s hold%0d out_valid", tag, s), 64'(out_valid[k]), 64'd1);
            @(negedge clk);
        end
        in_valid[k] = 1'b0;
        take(k);
        chk({tag, " idle after take"}, 64'(busy[k]), 64'd0);
    endtask

    task automatic b2b_test(input int k);
        logic [63:0]  bd [4];
        logic [63:0]  be [4];
        logic [127:0] bk [4];
        logic [63:0]  pt;
        int           acc_cyc [4];
        int           out_cyc [4];
        int           cyc, nacc, nout, ncyc;
        string        tag;
        tag  = $sformatf("u%0d b2b", un_of(k));
        ncyc = 12 / un_of(k);
        for (int b = 0; b < 4; b++) begin
            pt    = {$urandom, $urandom};
            bk[b] = {$urandom, $urandom, $urandom, $urandom};
            if (b % 2 == 0) begin
                bd[b] = pt;
                be[b] = ref_enc(pt, bk[b]);
            end else begin
                bd[b] = ref_enc(pt, bk[b]);
                be[b] = pt;
            end
            acc_cyc[b] = -100;
            out_cyc[b] = -100;
        end
        @(negedge clk);
        in_valid[k]  = 1'b1;
        in_mode[k]   = 1'b0;
        in_data[k]   = bd[0];
        in_key[k]    = bk[0];
        out_ready[k] = 1'b1;
        cyc = 0; nacc = 0; nout = 0;
        while (nout < 4 && cyc < 200) begin
            if (out_valid[k]) begin
                chk($sformatf("%s blk%0d data", tag, nout), out_data[k], be[nout]);
                out_cyc[nout] = cyc;
                nout++;
            end
            if (in_valid[k] && in_ready[k] && nacc < 4) begin
                acc_cyc[nacc] = cyc;
                nacc++;
            end
            @(negedge clk);
            cyc++;
            if (nacc < 4) begin
                in_valid[k] = 1'b1;
                in_mode[k]  = nacc[0];
                in_data[k]  = bd[nacc];
                in_key[k]   = bk[nacc];
            end else begin
                in_valid[k] = 1'b0;
            end
        end
        out_ready[k] = 1'b0;
        chk({tag, " outputs"}, 64'(nout), 64'd4);
        for (int b = 0; b < 4; b++)
            chk($sformatf("%s blk%0d latency", tag, b), 64'(out_cyc[b] - acc_cyc[b]), 64'(ncyc + 1));
        for (int b = 0; b < 3; b++)
            chk($sformatf("%s blk%0d spacing", tag, b), 64'(acc_cyc[b+1] - acc_cyc[b]), 64'(ncyc + 1));
    endtask

    task automatic reset_test;
        int nv;
        send(0, 1'b0, kat_pt[4], kat_key[4], "rst pre");
        @(negedge clk);
        rst_n[0] = 1'b0;
        #1;
        chk("rst out_valid", 64'(out_valid[0]), 64'd0);
        chk("rst busy", 64'(busy[0]), 64'd0);
        chk("rst in_ready", 64'(in_ready[0]), 64'd1);
        chk("rst out_data", out_data[0], 64'd0);
        @(negedge clk);
        rst_n[0] = 1'b1;
        nv = 0;
        for (int c = 0; c < 15; c++) begin
            if (out_valid[0] || busy[0]) nv++;
            @(negedge clk);
        end
        chk("rst no stale output", 64'(nv), 64'd0);
        run_block(0, 1'b0, kat_pt[4], kat_key[4], kat_ct[4], "rst post enc");
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [63:0] sb;
        logic [63:0]  pt, ct;
        logic [127:0] key;
        sb = 64'h4D5E087619CA23FB;
        for (int i = 0; i < 16; i++) sbox_t[i] = sb[4*i +: 4];
        rc_t[0] = 64'h0000000000000000;
        rc_t[1] = 64'h13198a2e03707344;
        rc_t[2] = 64'ha4093822299f31d0;
        rc_t[3] = 64'h082efa98ec4e6c89;
        rc_t[4] = 64'h452821e638d01377;
        rc_t[5] = 64'hbe5466cf34e90c6c;
        for (int i = 0; i < 6; i++) rc_t[11 - i] = rc_t[i] ^ ALPHA;
        kat_pt[0] = 64'h0;                kat_key[0] = {64'h0, 64'h0};                kat_ct[0] = 64'h818665aa0d02dfda;
        kat_pt[1] = 64'hffffffffffffffff; kat_key[1] = {64'h0, 64'h0};                kat_ct[1] = 64'h604ae6ca03c20ada;
        kat_pt[2] = 64'h0;                kat_key[2] = {64'hffffffffffffffff, 64'h0}; kat_ct[2] = 64'h9fb51935fc3df524;
        kat_pt[3] = 64'h0;                kat_key[3] = {64'h0, 64'hffffffffffffffff}; kat_ct[3] = 64'h78a54cbe737bb7ef;
        kat_pt[4] = 64'h0123456789abcdef; kat_key[4] = {64'h0, 64'hfedcba9876543210}; kat_ct[4] = 64'hae25ad3ca8fa9ccf;

        rst_n     = '0;
        in_valid  = '0;
        in_mode   = '0;
        in_data   = '0;
        in_key    = '0;
        out_ready = '0;
        repeat (3) @(negedge clk);
        rst_n = '1;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("u%0d reset in_ready", un_of(k)), 64'(in_ready[k]), 64'd1);
            chk($sformatf("u%0d reset out_valid", un_of(k)), 64'(out_valid[k]), 64'd0);
            chk($sformatf("u%0d reset out_data", un_of(k)), out_data[k], 64'd0);
            chk($sformatf("u%0d reset busy", un_of(k)), 64'(busy[k]), 64'd0);
        end

        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 5; i++) begin
                run_block(k, 1'b0, kat_pt[i], kat_key[i], kat_ct[i], $sformatf("u%0d kat%0d enc", un_of(k), i));
                run_block(k, 1'b1, kat_ct[i], kat_key[i], kat_pt[i], $sformatf("u%0d kat%0d dec", un_of(k), i));
            end
            for (int i = 0; i < 4; i++) begin
                pt  = {$urandom, $urandom};
                key = {$urandom, $urandom, $urandom, $urandom};
                ct  = ref_enc(pt, key);
                run_block(k, 1'b0, pt, key, ct, $sformatf("u%0d rnd%0d enc", un_of(k), i));
                run_block(k, 1'b1, ct, key, pt, $sformatf("u%0d rnd%0d dec", un_of(k), i));
            end
            stall_test(k);
            b2b_test(k);
        end

        reset_test();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got no summary, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
